// File: rtl/exception_sequencer.sv
// Precise exception / ERET sequencer: flushes the pipeline, issues one CP0 write bundle,
// then holds a PC redirect request toward fetch until it is acknowledged.
module exception_sequencer #(
  parameter logic [31:0] HANDLER_VEC  = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        pc_ack_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        cp0_we_o,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o,
  output logic        cp0_exl_set_o,
  output logic        cp0_exl_clr_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_vld_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] CODE_ERET  = 4'hd;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  code_r;
  logic [31:0] epc_r;
  logic        bd_r;
  logic [31:0] ds_pc_s;
  logic        take_s;

  function automatic logic is_event(input logic [31:0] t);
    return (t[31:4] == 28'd0) && (t[3:0] != 4'h0) && (t[3:0] <= CODE_ERET);
  endfunction

  function automatic logic [4:0] exccode_of(input logic [3:0] code);
    case (code)
      4'h9:    return 5'h08;
      4'ha:    return 5'h0a;
      4'hb:    return 5'h0d;
      4'hc:    return 5'h0c;
      default: return 5'h00;
    endcase
  endfunction

  assign ds_pc_s = mem_pc_i - 32'd4;
  assign take_s  = exc_valid_i && is_event(excepttype_i);

  // Sequencer state, latched exception context and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      code_r        <= 4'd0;
      epc_r         <= 32'd0;
      bd_r          <= 1'b0;
      flush_o       <= 1'b0;
      stall_o       <= 1'b0;
      cp0_we_o      <= 1'b0;
      cp0_epc_o     <= 32'd0;
      cp0_exccode_o <= 5'd0;
      cp0_bd_o      <= 1'b0;
      cp0_exl_set_o <= 1'b0;
      cp0_exl_clr_o <= 1'b0;
      new_pc_o      <= 32'd0;
      new_pc_vld_o  <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            state_r <= FLUSH;
            cnt_r   <= FLUSH_INIT;
            code_r  <= excepttype_i[3:0];
            epc_r   <= mem_in_ds_i ? ds_pc_s : mem_pc_i;
            bd_r    <= mem_in_ds_i;
            flush_o <= 1'b1;
            stall_o <= 1'b1;
            busy_o  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt_r == 4'd0) begin
            state_r  <= COMMIT;
            flush_o  <= 1'b0;
            cp0_we_o <= 1'b1;
            // ERET carries no context; CP0 only needs the EXL clear.
            if (code_r == CODE_ERET) begin
              cp0_exl_clr_o <= 1'b1;
            end else begin
              cp0_epc_o     <= epc_r;
              cp0_exccode_o <= exccode_of(code_r);
              cp0_bd_o      <= bd_r;
              cp0_exl_set_o <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        COMMIT: begin
          state_r       <= REDIRECT;
          cp0_we_o      <= 1'b0;
          cp0_epc_o     <= 32'd0;
          cp0_exccode_o <= 5'd0;
          cp0_bd_o      <= 1'b0;
          cp0_exl_set_o <= 1'b0;
          cp0_exl_clr_o <= 1'b0;
          new_pc_vld_o  <= 1'b1;
          new_pc_o      <= (code_r == CODE_ERET) ? cp0_epc_i : HANDLER_VEC;
        end
        REDIRECT: begin
          if (pc_ack_i) begin
            state_r      <= IDLE;
            new_pc_vld_o <= 1'b0;
            new_pc_o     <= 32'd0;
            stall_o      <= 1'b0;
            busy_o       <= 1'b0;
          end else begin
            state_r <= REDIRECT;
          end
        end
        default: begin
          state_r       <= IDLE;
          flush_o       <= 1'b0;
          stall_o       <= 1'b0;
          cp0_we_o      <= 1'b0;
          cp0_exl_set_o <= 1'b0;
          cp0_exl_clr_o <= 1'b0;
          new_pc_vld_o  <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: stimulus pushes expected CP0 bundles and redirect
// targets, a negedge monitor pops and compares them whenever the DUT presents them.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        exc_valid_i = 1'b0;
  logic [31:0] excepttype_i = 32'd0;
  logic [31:0] mem_pc_i = 32'd0;
  logic        mem_in_ds_i = 1'b0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic        pc_ack_i = 1'b0;
  logic        flush_o, stall_o, cp0_we_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o;
  logic        new_pc_vld_o, busy_o;
  logic [31:0] cp0_epc_o, new_pc_o;
  logic [4:0]  cp0_exccode_o;

  exception_sequencer dut (
    .clk(clk), .rst_n(rst_n), .exc_valid_i(exc_valid_i), .excepttype_i(excepttype_i),
    .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i), .cp0_epc_i(cp0_epc_i), .pc_ack_i(pc_ack_i),
    .flush_o(flush_o), .stall_o(stall_o), .cp0_we_o(cp0_we_o), .cp0_epc_o(cp0_epc_o),
    .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o), .cp0_exl_set_o(cp0_exl_set_o),
    .cp0_exl_clr_o(cp0_exl_clr_o), .new_pc_o(new_pc_o), .new_pc_vld_o(new_pc_vld_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        set;
    logic        clr;
  } cp0_t;

  cp0_t        exp_cp0[$];
  logic [31:0] exp_pc[$];
  cp0_t        e;
  logic [31:0] p;
  int          checks = 0;
  int          failures = 0;
  int          fcnt = 0;
  logic        prev_flush = 1'b0, prev_we = 1'b0, prev_vld = 1'b0;
  logic [31:0] prev_pc = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cp0_we_o) begin
        if (exp_cp0.size() == 0) begin
          chk("cp0_unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_cp0.pop_front();
          chk("cp0_bundle", {24'd0, cp0_epc_o, cp0_exccode_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o},
              {24'd0, e});
          chk("cp0_after_flush", {62'd0, prev_flush, stall_o}, 64'd3);
        end
      end
      if (flush_o) fcnt++;
      else if (fcnt != 0) begin
        chk("flush_length", 64'(fcnt), 64'd2);
        fcnt = 0;
      end
      if (new_pc_vld_o && !prev_vld) chk("redirect_after_commit", {63'd0, prev_we}, 64'd1);
      if (new_pc_vld_o && prev_vld) chk("redirect_stable", {32'd0, new_pc_o}, {32'd0, prev_pc});
      if (new_pc_vld_o && pc_ack_i) begin
        if (exp_pc.size() == 0) begin
          chk("redirect_unexpected", 64'd1, 64'd0);
        end else begin
          p = exp_pc.pop_front();
          chk("redirect_pc", {32'd0, new_pc_o}, {32'd0, p});
        end
      end
      prev_flush = flush_o;
      prev_we    = cp0_we_o;
      prev_vld   = new_pc_vld_o;
      prev_pc    = new_pc_o;
    end else begin
      fcnt = 0;
      prev_flush = 1'b0;
      prev_we = 1'b0;
      prev_vld = 1'b0;
    end
  end

  task automatic wait_vld(output logic ok);
    int n = 0;
    while (!new_pc_vld_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = new_pc_vld_o;
    chk("redirect_seen", {63'd0, new_pc_vld_o}, 64'd1);
  endtask

  task automatic run_seq(input logic [3:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] x_epc, input logic [4:0] x_exc, input logic x_bd,
                         input logic [31:0] x_pc, input int ack_delay, input logic hold3);
    logic ok;
    @(posedge clk); #1;
    exc_valid_i = 1'b1; excepttype_i = {28'd0, code}; mem_pc_i = pc; mem_in_ds_i = ds;
    exp_cp0.push_back({x_epc, x_exc, x_bd, code != 4'hd, code == 4'hd});
    exp_pc.push_back(x_pc);
    @(posedge clk); #1;
    if (hold3) begin
      excepttype_i = 32'd3;
    end else begin
      exc_valid_i = 1'b0; excepttype_i = 32'd0;
    end
    wait_vld(ok);
    if (!ok) begin
      exp_cp0.delete(); exp_pc.delete(); exc_valid_i = 1'b0;
      return;
    end
    repeat (ack_delay) begin @(posedge clk); #1; end
    pc_ack_i = 1'b1; exc_valid_i = 1'b0; excepttype_i = 32'd0;
    @(posedge clk); #1;
    pc_ack_i = 1'b0;
    chk("idle_after_ack", {60'd0, busy_o, stall_o, new_pc_vld_o, flush_o}, 64'd0);
  endtask

  task automatic idle_check(input string name, input logic vld, input logic [31:0] t);
    logic bad = 1'b0;
    @(posedge clk); #1;
    exc_valid_i = vld; excepttype_i = t; mem_pc_i = 32'h8000_4000;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy_o || flush_o || cp0_we_o || new_pc_vld_o) bad = 1'b1;
    end
    exc_valid_i = 1'b0; excepttype_i = 32'd0;
    chk(name, {63'd0, bad}, 64'd0);
  endtask

  initial begin
    logic ok;
    logic bad;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {49'd0, flush_o, stall_o, cp0_we_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o,
        new_pc_vld_o, busy_o, cp0_exccode_o, 1'b0}, 64'd0);
    chk("reset_data", {cp0_epc_o, new_pc_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // syscall, delay-slot overflow, ERET with a 5-cycle ack stall, interrupt with code 3 held
    run_seq(4'h9, 32'h8000_1000, 1'b0, 32'h8000_1000, 5'h08, 1'b0, 32'hBFC0_0380, 0, 1'b0);
    run_seq(4'hc, 32'h8000_2004, 1'b1, 32'h8000_2000, 5'h0c, 1'b1, 32'hBFC0_0380, 1, 1'b0);
    cp0_epc_i = 32'h8000_3000;
    run_seq(4'hd, 32'h8000_5000, 1'b0, 32'h0000_0000, 5'h00, 1'b0, 32'h8000_3000, 5, 1'b0);
    run_seq(4'h3, 32'h8000_6000, 1'b0, 32'h8000_6000, 5'h00, 1'b0, 32'hBFC0_0380, 2, 1'b1);
    run_seq(4'hb, 32'h8000_7008, 1'b1, 32'h8000_7004, 5'h0d, 1'b1, 32'hBFC0_0380, 0, 1'b0);

    idle_check("ignore_code_e", 1'b1, 32'h0000_000e);
    idle_check("ignore_not_valid", 1'b0, 32'h0000_0009);
    idle_check("ignore_upper_bits", 1'b1, 32'h0000_0019);

    // async reset while a redirect is pending
    @(posedge clk); #1;
    exc_valid_i = 1'b1; excepttype_i = 32'h0000_000a; mem_pc_i = 32'h8000_8000; mem_in_ds_i = 1'b0;
    exp_cp0.push_back({32'h8000_8000, 5'h0a, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    exc_valid_i = 1'b0; excepttype_i = 32'd0;
    wait_vld(ok);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {49'd0, flush_o, stall_o, cp0_we_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o,
        new_pc_vld_o, busy_o, cp0_exccode_o, 1'b0}, 64'd0);
    chk("abort_data", {cp0_epc_o, new_pc_o}, 64'd0);
    exp_pc.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy_o || cp0_we_o || new_pc_vld_o) bad = 1'b1;
    end
    chk("abort_stays_idle", {63'd0, bad}, 64'd0);

    repeat (3) @(posedge clk);
    chk("cp0_queue_drained", 64'(exp_cp0.size()), 64'd0);
    chk("pc_queue_drained", 64'(exp_pc.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
